alu_execute: RTL
================

# alu_execute

Execute-stage ALU of the 5-stage MIPS32 pipeline. Sits directly downstream of the ALU decoder and consumes its 4-bit ALU control code together with the two ID/EX operands. Produces a registered result for the EX/MEM register. Single-cycle ops complete in one cycle; MUL uses an 8-step iterative radix-16 multiplier and stalls the upstream stage while it runs.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- MUL_STEPS, 8, multiplier iterations (4 multiplier bits per step; WIDTH = 4*MUL_STEPS)

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- inValid  in  1  operands and control valid this cycle
- aluController  in  4  op code from the decoder
- srcA  in  WIDTH  operand A
- srcB  in  WIDTH  operand B
- flush  in  1  synchronous kill of the in-flight op
- busy  out  1  registered; upstream must hold ID/EX while high
- outValid  out  1  one-cycle pulse, aluResult/zero updated
- aluResult  out  WIDTH  registered result
- zero  out  1  registered, (aluResult == 0)

## Operation
- Op codes: 0000 ADD, 0001 SUB, 0010 MUL, 0011 SLT, 0100 AND, 0101 OR, 0110 XOR, 0111 NOR; 1000-1111 execute as ADD.
- ADD/SUB wrap modulo 2^WIDTH, no overflow detection. SLT: signed compare, result 1 or 0 zero-extended. MUL: low WIDTH bits of product (identical for signed/unsigned).
- FSM states IDLE, MUL.
- IDLE, inValid, non-MUL op: aluResult/zero written, outValid=1 next cycle, stay IDLE.
- IDLE, inValid, MUL: latch srcA (multiplicand), srcB (multiplier), acc=0, cnt=0 -> MUL. No outValid for this edge.
- MUL, each edge: acc += (mcand * mplier[3:0]) << 4*cnt (mod 2^WIDTH); mplier >>= 4; cnt++. At edge with cnt==MUL_STEPS-1: aluResult = final acc, outValid=1, -> IDLE.
- Inputs (inValid, operands, op) ignored while in MUL.
- flush (priority over inValid): in MUL -> IDLE, no result written; in IDLE -> op not accepted; outValid=0 next cycle; aluResult holds.
- aluResult/zero hold value between outValid pulses.

## Timing
- Reset: state IDLE, busy=0, outValid=0, aluResult=0, zero=1, cnt=0, acc=0.
- Non-MUL latency: 1 cycle (accepted edge -> outValid high the following cycle). Back-to-back accepts every cycle.
- MUL latency: 9 edges from accept edge E0 to result; outValid high in the cycle after E8.
- busy = (state == MUL): high for exactly 8 cycles after E0, low in the cycle outValid is high, so the next op is accepted in that same cycle.
- busy is registered; no combinational path from any input to busy.
- Reset asserted mid-MUL: immediate return to reset values; partial product discarded.
- flush and the final MUL step on the same edge: flush wins, no outValid.

## Structure
- Shared package alu_pkg: op-code localparams (ALU_ADD … ALU_NOR, same encoding as the decoder output), MUL_STEPS, FSM state encoding. Decoder and this block import the same package.
- One sub-module natural: mul_iter (operand/acc/cnt registers and radix-16 step datapath, start/flush inputs, done output). Single-cycle ops and result register stay in alu_execute.

## Test plan
- Reset mid-MUL: start 0x12345678*3, assert rst at step 4 -> busy=0, outValid=0, aluResult=0, zero=1 immediately; next ADD 1+2 -> 3 after 1 cycle.
- ADD 0xFFFFFFFF+1 -> aluResult=0, zero=1, outValid 1 cycle later; SUB 5-7 -> 0xFFFFFFFE, zero=0.
- SLT 0xFFFFFFFF (-1) vs 1 -> 1; SLT 1 vs 0xFFFFFFFF -> 0; NOR 0,0 -> 0xFFFFFFFF; op 1010 with 2,3 -> 5.
- MUL 0x0001_0001*0x0001_0001 -> 0x0002_0001; MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001; busy high exactly 8 cycles, outValid in cycle after 8th step; ADD presented during busy ignored, ADD held and accepted in outValid cycle -> result next cycle.
- flush at MUL step 3 -> busy low next cycle, no outValid, aluResult keeps previous value; flush with inValid ADD in IDLE -> no outValid.
- Random back-to-back mix of all 8 ops vs golden model, checking outValid count equals accepted non-flushed ops.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code encoding (matches the ALU decoder output),
// multiplier step count and execute-stage FSM state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_MUL = 4'b0010;
    localparam logic [3:0] ALU_SLT = 4'b0011;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b0111;

    localparam int ALU_MUL_STEPS = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_t;

    function automatic logic is_mul_op(input logic [3:0] op);
        return op == ALU_MUL;
    endfunction

endpackage

// File: rtl/alu_execute_mul_iter.sv
// Iterative radix-16 multiplier: four multiplier bits per step, low WIDTH
// bits of the product accumulated in place.
module mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MUL_STEPS = ALU_MUL_STEPS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic             flush,
    input  logic [WIDTH-1:0] mcand_in,
    input  logic [WIDTH-1:0] mplier_in,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(MUL_STEPS - 1);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] digit;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] acc_next;

    always_comb begin
        digit    = {{(WIDTH-4){1'b0}}, mplier[3:0]};
        partial  = (mcand * digit) << {cnt, 2'b00};
        acc_next = acc + partial;
    end

    // acc_next on the last step is the final product, consumed on the same edge
    assign done    = step && !flush && (cnt == LAST);
    assign product = acc_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (start) begin
            mcand  <= mcand_in;
            mplier <= mplier_in;
            acc    <= '0;
            cnt    <= '0;
        end else if (flush) begin
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            acc    <= acc_next;
            mplier <= mplier >> 4;
            cnt    <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_execute.sv
// Execute-stage ALU: single-cycle ops straight into the result register,
// MUL handed to mul_iter while busy stalls the ID/EX stage.
//
// state   | meaning
// IDLE    | accepting ops; non-MUL ops complete on the accept edge
// MUL     | multiplier stepping, inputs ignored, busy high
module alu_execute
    import alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MUL_STEPS = ALU_MUL_STEPS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    input  logic [3:0]       aluController,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             flush,
    output logic             busy,
    output logic             outValid,
    output logic [WIDTH-1:0] aluResult,
    output logic             zero
);

    alu_state_t       state;
    logic [WIDTH-1:0] single_res;
    logic             slt;
    logic             accept;
    logic             mul_start;
    logic             mul_step;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    always_comb begin
        slt        = $signed(srcA) < $signed(srcB);
        single_res = srcA + srcB;
        case (aluController)
            ALU_SUB: single_res = srcA - srcB;
            ALU_SLT: single_res = {{(WIDTH-1){1'b0}}, slt};
            ALU_AND: single_res = srcA & srcB;
            ALU_OR:  single_res = srcA | srcB;
            ALU_XOR: single_res = srcA ^ srcB;
            ALU_NOR: single_res = ~(srcA | srcB);
            default: single_res = srcA + srcB;
        endcase
    end

    assign accept    = (state == ST_IDLE) && inValid && !flush;
    assign mul_start = accept && is_mul_op(aluController);
    assign mul_step  = (state == ST_MUL);

    mul_iter #(
        .WIDTH     (WIDTH),
        .MUL_STEPS (MUL_STEPS)
    ) u_mul_iter (
        .clk       (clk),
        .rst       (rst),
        .start     (mul_start),
        .step      (mul_step),
        .flush     (flush),
        .mcand_in  (srcA),
        .mplier_in (srcB),
        .done      (mul_done),
        .product   (mul_product)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            outValid  <= 1'b0;
            aluResult <= '0;
            zero      <= 1'b1;
        end else begin
            outValid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mul_start) begin
                        state <= ST_MUL;
                        busy  <= 1'b1;
                    end else if (accept) begin
                        aluResult <= single_res;
                        zero      <= (single_res == '0);
                        outValid  <= 1'b1;
                    end
                end
                ST_MUL: begin
                    // flush outranks the final step, so mul_done is already gated
                    if (flush) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (mul_done) begin
                        aluResult <= mul_product;
                        zero      <= (mul_product == '0);
                        outValid  <= 1'b1;
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
